// File: rtl/packet_scheduler.sv
// ---------------------------------------------------------------------------
// PacketScheduler: decides which HDMI data-island packet the transmitter sends
// next. Audio samples pre-empt InfoFrames when the sample buffer is filling
// up. Otherwise per-frame housekeeping packets (ACR, Audio InfoFrame, AVI
// InfoFrame) are sent in that order. Leftover slots drain audio, or carry a
// null packet when no audio is buffered.
//
// Ports:
//    clk_pixel                 pixel clock, all logic on its rising edge
//    reset                     asynchronous active-high reset
//    frame_start               one-cycle pulse at pixel (0,0)
//    packet_enable             one-cycle request for the next packet type
//    remaining[6:0]            audio samples buffered and ready
//    packet_type[7:0]          registered packet type granted to hdmi
//    audio_pop                 one-cycle pulse with each 0x02 grant
//    audio_packets_last_frame  0x02 grants in the previous frame (saturating)
//    starved                   sticky: full audio buffer passed over for a slot
// ---------------------------------------------------------------------------
module packet_scheduler #(
   parameter int unsigned AUDIO_URGENT_LEVEL = 7'd16,
   parameter int unsigned ACR_PERIOD_FRAMES  = 1,
   parameter int unsigned AVI_ENABLE         = 1
) (
   input  logic       clk_pixel,
   input  logic       reset,
   input  logic       frame_start,
   input  logic       packet_enable,
   input  logic [6:0] remaining,
   output logic [7:0] packet_type,
   output logic       audio_pop,
   output logic [7:0] audio_packets_last_frame,
   output logic       starved
);

   localparam logic [7:0] PKT_NULL  = 8'h00;
   localparam logic [7:0] PKT_ACR   = 8'h01;
   localparam logic [7:0] PKT_AUDIO = 8'h02;
   localparam logic [7:0] PKT_AVI   = 8'h82;
   localparam logic [7:0] PKT_AIF   = 8'h84;

   localparam logic [3:0] ACR_PERIOD = 4'(ACR_PERIOD_FRAMES);
   localparam logic       AVI_ON     = (AVI_ENABLE != 0);

   logic       acrPend_q, acrPend_d;
   logic       aifPend_q, aifPend_d;
   logic       aviPend_q, aviPend_d;
   logic [3:0] fcnt_q, fcnt_d;
   logic [7:0] audioCnt_q, audioCnt_d;
   logic [7:0] lastFrame_q, lastFrame_d;
   logic [7:0] packetType_q, packetType_d;
   logic       audioPop_q, audioPop_d;
   logic       starved_q, starved_d;

   logic [3:0] fcntInc;
   logic       acrHit;
   logic       acrEff, aifEff, aviEff;
   logic       urgent;
   logic [7:0] grantType;
   logic       grantAudio;

   // Flags seen by the arbiter already include a frame_start arriving in the
   // same cycle, so a grant can take a packet that was queued that very edge.
   // A granted flag is cleared on the grant edge. A flag that is still pending
   // when a new frame arrives simply stays set.
   always_comb begin
      fcntInc = fcnt_q + 4'd1;
      acrHit  = frame_start && (fcntInc == ACR_PERIOD);
      acrEff  = acrPend_q | acrHit;
      aifEff  = aifPend_q | frame_start;
      aviEff  = aviPend_q | (frame_start & AVI_ON);
      urgent  = 32'(remaining) >= AUDIO_URGENT_LEVEL;

      fcnt_d = fcnt_q;
      if (frame_start) begin
         fcnt_d = acrHit ? 4'd0 : fcntInc;
      end

      grantType  = PKT_NULL;
      grantAudio = 1'b0;
      if (urgent) begin
         grantType  = PKT_AUDIO;
         grantAudio = 1'b1;
      end else if (acrEff) begin
         grantType = PKT_ACR;
      end else if (aifEff) begin
         grantType = PKT_AIF;
      end else if (aviEff) begin
         grantType = PKT_AVI;
      end else if (remaining != 7'd0) begin
         grantType  = PKT_AUDIO;
         grantAudio = 1'b1;
      end

      acrPend_d    = acrEff;
      aifPend_d    = aifEff;
      aviPend_d    = aviEff;
      packetType_d = packetType_q;
      audioPop_d   = 1'b0;
      starved_d    = starved_q;
      if (packet_enable) begin
         packetType_d = grantType;
         audioPop_d   = grantAudio;
         if (grantType == PKT_ACR) acrPend_d = 1'b0;
         if (grantType == PKT_AIF) aifPend_d = 1'b0;
         if (grantType == PKT_AVI) aviPend_d = 1'b0;
         if (remaining == 7'h7f && !grantAudio) starved_d = 1'b1;
      end

      // A 0x02 grant in the frame_start cycle is counted towards the new frame.
      lastFrame_d = frame_start ? audioCnt_q : lastFrame_q;
      audioCnt_d  = frame_start ? 8'd0 : audioCnt_q;
      if (packet_enable && grantAudio && audioCnt_d != 8'hff) begin
         audioCnt_d = audioCnt_d + 8'd1;
      end
   end

   // State register. Reset throws away any queued packets immediately.
   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         acrPend_q    <= 1'b0;
         aifPend_q    <= 1'b0;
         aviPend_q    <= 1'b0;
         fcnt_q       <= 4'd0;
         audioCnt_q   <= 8'd0;
         lastFrame_q  <= 8'd0;
         packetType_q <= PKT_NULL;
         audioPop_q   <= 1'b0;
         starved_q    <= 1'b0;
      end else begin
         acrPend_q    <= acrPend_d;
         aifPend_q    <= aifPend_d;
         aviPend_q    <= aviPend_d;
         fcnt_q       <= fcnt_d;
         audioCnt_q   <= audioCnt_d;
         lastFrame_q  <= lastFrame_d;
         packetType_q <= packetType_d;
         audioPop_q   <= audioPop_d;
         starved_q    <= starved_d;
      end
   end

   assign packet_type              = packetType_q;
   assign audio_pop                = audioPop_q;
   assign audio_packets_last_frame = lastFrame_q;
   assign starved                  = starved_q;

endmodule

// File: tb/tb_packet_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for packet_scheduler. Two instances share the same stimulus:
//    dut  - default parameters (urgent level 16, ACR every frame, AVI on)
//    dut3 - ACR every 3 frames, AVI off, urgent level 200 (so starvation
//           can actually occur)
// A directed vector table exercises the default instance. Hand-written
// sequences then cover counter saturation, mid-frame reset, the ACR period
// and the starved flag.
// ---------------------------------------------------------------------------
module tb_packet_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       frameStart;
   logic       packetEnable;
   logic [6:0] remaining;

   logic [7:0] pktType, lastCnt;
   logic       audioPop, starved;
   logic [7:0] pktType3, lastCnt3;
   logic       audioPop3, starved3;

   int assertCount = 0;
   int failCount   = 0;

   packet_scheduler dut (
      .clk_pixel                (clk),
      .reset                    (reset),
      .frame_start              (frameStart),
      .packet_enable            (packetEnable),
      .remaining                (remaining),
      .packet_type              (pktType),
      .audio_pop                (audioPop),
      .audio_packets_last_frame (lastCnt),
      .starved                  (starved)
   );

   packet_scheduler #(
      .AUDIO_URGENT_LEVEL (200),
      .ACR_PERIOD_FRAMES  (3),
      .AVI_ENABLE         (0)
   ) dut3 (
      .clk_pixel                (clk),
      .reset                    (reset),
      .frame_start              (frameStart),
      .packet_enable            (packetEnable),
      .remaining                (remaining),
      .packet_type              (pktType3),
      .audio_pop                (audioPop3),
      .audio_packets_last_frame (lastCnt3),
      .starved                  (starved3)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       fs;
      logic       pe;
      logic [6:0] rem;
      logic [7:0] expType;
      logic       expPop;
   } vec_t;

   vec_t vecs[27];

   function automatic vec_t mkVec(input logic fs, input logic pe, input logic [6:0] rem,
                                  input logic [7:0] expType, input logic expPop);
      vec_t v;
      v.fs      = fs;
      v.pe      = pe;
      v.rem     = rem;
      v.expType = expType;
      v.expPop  = expPop;
      return v;
   endfunction

   // Drive one cycle of inputs, let the edge happen, then drop the pulses.
   // The caller is left 1 time unit after the edge, ready to sample.
   task automatic applyStimulus(input logic fs, input logic pe, input logic [6:0] rem);
      frameStart   = fs;
      packetEnable = pe;
      remaining    = rem;
      @(posedge clk);
      #1;
      frameStart   = 1'b0;
      packetEnable = 1'b0;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   int curModel;
   int lastModel;
   int popSeen;

   initial begin
      // Default-instance vectors: {frame_start, packet_enable, remaining, type, pop}
      vecs[0]  = mkVec(1'b0, 1'b1, 7'd0,  8'h00, 1'b0);
      vecs[1]  = mkVec(1'b0, 1'b1, 7'd5,  8'h02, 1'b1);
      vecs[2]  = mkVec(1'b0, 1'b0, 7'd5,  8'h02, 1'b0);
      vecs[3]  = mkVec(1'b1, 1'b0, 7'd0,  8'h02, 1'b0);
      vecs[4]  = mkVec(1'b0, 1'b1, 7'd0,  8'h01, 1'b0);
      vecs[5]  = mkVec(1'b0, 1'b1, 7'd0,  8'h84, 1'b0);
      vecs[6]  = mkVec(1'b0, 1'b1, 7'd0,  8'h82, 1'b0);
      vecs[7]  = mkVec(1'b0, 1'b1, 7'd0,  8'h00, 1'b0);
      vecs[8]  = mkVec(1'b0, 1'b0, 7'd0,  8'h00, 1'b0);
      vecs[9]  = mkVec(1'b1, 1'b1, 7'd0,  8'h01, 1'b0);
      vecs[10] = mkVec(1'b0, 1'b1, 7'd20, 8'h02, 1'b1);
      vecs[11] = mkVec(1'b0, 1'b0, 7'd3,  8'h02, 1'b0);
      vecs[12] = mkVec(1'b0, 1'b1, 7'd3,  8'h84, 1'b0);
      vecs[13] = mkVec(1'b1, 1'b0, 7'd3,  8'h84, 1'b0);
      vecs[14] = mkVec(1'b1, 1'b0, 7'd3,  8'h84, 1'b0);
      vecs[15] = mkVec(1'b0, 1'b1, 7'd3,  8'h01, 1'b0);
      vecs[16] = mkVec(1'b0, 1'b1, 7'd3,  8'h84, 1'b0);
      vecs[17] = mkVec(1'b0, 1'b1, 7'd3,  8'h82, 1'b0);
      vecs[18] = mkVec(1'b0, 1'b1, 7'd3,  8'h02, 1'b1);
      vecs[19] = mkVec(1'b0, 1'b1, 7'd16, 8'h02, 1'b1);
      vecs[20] = mkVec(1'b0, 1'b1, 7'd0,  8'h00, 1'b0);
      vecs[21] = mkVec(1'b1, 1'b0, 7'd20, 8'h00, 1'b0);
      vecs[22] = mkVec(1'b0, 1'b1, 7'd20, 8'h02, 1'b1);
      vecs[23] = mkVec(1'b0, 1'b1, 7'd3,  8'h01, 1'b0);
      vecs[24] = mkVec(1'b0, 1'b1, 7'd15, 8'h84, 1'b0);
      vecs[25] = mkVec(1'b0, 1'b1, 7'd15, 8'h82, 1'b0);
      vecs[26] = mkVec(1'b0, 1'b1, 7'd15, 8'h02, 1'b1);

      reset        = 1'b1;
      frameStart   = 1'b0;
      packetEnable = 1'b0;
      remaining    = 7'd0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset packet_type", int'(pktType), 'h00);
      checkOutput("reset audio_pop", int'(audioPop), 0);
      checkOutput("reset last_frame", int'(lastCnt), 0);
      checkOutput("reset starved", int'(starved), 0);
      checkOutput("reset dut3 packet_type", int'(pktType3), 'h00);
      reset = 1'b0;

      // Table-driven run with a small model of the per-frame audio counter
      curModel  = 0;
      lastModel = 0;
      for (int i = 0; i < 27; i++) begin
         applyStimulus(vecs[i].fs, vecs[i].pe, vecs[i].rem);
         if (vecs[i].fs) begin
            lastModel = curModel;
            curModel  = 0;
         end
         if (vecs[i].expPop && curModel < 255) curModel++;
         checkOutput($sformatf("vec%0d packet_type", i), int'(pktType), int'(vecs[i].expType));
         checkOutput($sformatf("vec%0d audio_pop", i), int'(audioPop), int'(vecs[i].expPop));
         checkOutput($sformatf("vec%0d last_frame", i), int'(lastCnt), lastModel);
         checkOutput($sformatf("vec%0d starved", i), int'(starved), 0);
      end

      // Saturation of the per-frame audio counter
      applyStimulus(1'b1, 1'b0, 7'd20);
      checkOutput("sat prior frame count", int'(lastCnt), 2);
      popSeen = 0;
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b0, 1'b1, 7'd20);
         if (audioPop === 1'b1 && pktType === 8'h02) popSeen++;
      end
      checkOutput("sat 300 back-to-back pops", popSeen, 300);
      applyStimulus(1'b1, 1'b0, 7'd20);
      checkOutput("sat last_frame 255", int'(lastCnt), 255);
      checkOutput("sat pop after frame", int'(audioPop), 0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 7'd20);
      applyStimulus(1'b1, 1'b0, 7'd0);
      checkOutput("sat last_frame 5", int'(lastCnt), 5);

      // Mid-frame asynchronous reset discards queued InfoFrames
      applyStimulus(1'b1, 1'b1, 7'd0);
      checkOutput("pre-reset grant acr", int'(pktType), 'h01);
      #2 reset = 1'b1;
      #1;
      checkOutput("async reset packet_type", int'(pktType), 'h00);
      checkOutput("async reset starved", int'(starved), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      applyStimulus(1'b0, 1'b1, 7'd0);
      checkOutput("post-reset no aif", int'(pktType), 'h00);
      applyStimulus(1'b0, 1'b1, 7'd0);
      checkOutput("post-reset no avi", int'(pktType), 'h00);

      // ACR period of 3 frames, AVI disabled, on dut3
      for (int f = 1; f <= 4; f++) begin
         applyStimulus(1'b1, 1'b0, 7'd0);
         if (f == 3) begin
            applyStimulus(1'b0, 1'b1, 7'd0);
            checkOutput($sformatf("acr3 frame%0d acr", f), int'(pktType3), 'h01);
         end
         applyStimulus(1'b0, 1'b1, 7'd0);
         checkOutput($sformatf("acr3 frame%0d aif", f), int'(pktType3), 'h84);
         applyStimulus(1'b0, 1'b1, 7'd0);
         checkOutput($sformatf("acr3 frame%0d idle", f), int'(pktType3), 'h00);
         checkOutput($sformatf("acr3 frame%0d pop", f), int'(audioPop3), 0);
      end

      // Starvation: full buffer passed over for an InfoFrame on dut3
      checkOutput("starved3 before", int'(starved3), 0);
      applyStimulus(1'b1, 1'b0, 7'd127);
      applyStimulus(1'b0, 1'b1, 7'd127);
      checkOutput("starve grant aif", int'(pktType3), 'h84);
      checkOutput("starve flag set", int'(starved3), 1);
      checkOutput("default urgent at 127", int'(pktType), 'h02);
      checkOutput("default never starved", int'(starved), 0);
      applyStimulus(1'b0, 1'b1, 7'd127);
      checkOutput("starve then audio", int'(pktType3), 'h02);
      checkOutput("starve then pop", int'(audioPop3), 1);
      checkOutput("starve sticky", int'(starved3), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/packet_scheduler.md
PACKET_SCHEDULER -- requirements
Module: packet_scheduler

Interface
REQ-001 SHALL have parameter AUDIO_URGENT_LEVEL, default 7'd16: buffered-sample level at which audio samples pre-empt InfoFrames.
REQ-002 SHALL have parameter ACR_PERIOD_FRAMES, default 1: number of frames between Audio Clock Regeneration packets, range 1..15.
REQ-003 SHALL have parameter AVI_ENABLE, default 1: 1 = schedule AVI InfoFrame (0x82) each frame; 0 = never.
REQ-004 SHALL have port clk_pixel, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port frame_start, input, 1 bit: one-cycle pulse at pixel (0,0).
REQ-007 SHALL have port packet_enable, input, 1 bit: one-cycle pulse from hdmi requesting the next packet_type.
REQ-008 SHALL have port remaining, input, 7 bits: audio samples buffered and ready.
REQ-009 SHALL have port packet_type, output, 8 bits: registered packet type for hdmi.
REQ-010 SHALL have port audio_pop, output, 1 bit: one-cycle pulse when a sample packet (0x02) is granted; drives the buffer's packet_enable.
REQ-011 SHALL have port audio_packets_last_frame, output, 8 bits: count of 0x02 grants in the previous frame, saturating at 255.
REQ-012 SHALL have port starved, output, 1 bit: sticky flag set when a slot passes with remaining == 127 unserved.

Function
REQ-013 SHALL keep pending flags acr_pend, aif_pend and avi_pend, plus frame counter fcnt (4 bits).
REQ-014 On frame_start, SHALL set aif_pend; SHALL set avi_pend if AVI_ENABLE; SHALL increment fcnt.
REQ-015 On frame_start, when fcnt+1 == ACR_PERIOD_FRAMES, SHALL set acr_pend and wrap fcnt to 0.
REQ-016 On frame_start, SHALL copy the current-frame 0x02 counter to audio_packets_last_frame and clear the counter.
REQ-017 On packet_enable, SHALL select packet_type by priority using flags as updated by any frame_start in the same cycle:
 1. remaining >= AUDIO_URGENT_LEVEL -> 0x02;
 2. acr_pend -> 0x01;
 3. aif_pend -> 0x84;
 4. avi_pend -> 0x82;
 5. remaining > 0 -> 0x02;
 6. otherwise -> 0x00.
REQ-018 SHALL clear the granted pending flag in the same edge as the grant; at most one packet is granted per packet_enable.
REQ-019 SHALL update packet_type one cycle after packet_enable (latency 1) and SHALL hold it until the next packet_enable.
REQ-020 SHALL pulse audio_pop high for exactly the one cycle in which packet_type updates to 0x02; otherwise 0.
REQ-021 SHALL set starved when packet_enable arrives with remaining == 127 and the grant is not 0x02 (impossible with default parameters; reachable if AUDIO_URGENT_LEVEL > 127); cleared only by reset.
REQ-022 If frame_start arrives while a flag is still pending, SHALL leave the flag set (no double-queueing, no loss).
REQ-023 Back-to-back packet_enable pulses on consecutive cycles SHALL each yield an independent grant.
REQ-024 The audio packet counter SHALL saturate at 255, never wrap.

Reset
REQ-025 While reset is high, SHALL drive packet_type = 0x00, audio_pop = 0, audio_packets_last_frame = 0, starved = 0.
REQ-026 While reset is high, SHALL clear all pending flags, fcnt and the frame counter.
REQ-027 After reset release, SHALL grant nothing but 0x02/0x00 until the first frame_start.
REQ-028 Reset asserted mid-frame SHALL discard pending flags immediately and asynchronously.

Verification
REQ-029 Reset, frame_start, remaining=0, three packet_enable -> packet_type 0x01, 0x84, 0x82 (each one cycle after its enable); fourth -> 0x00; audio_pop never high.
REQ-030 frame_start and packet_enable in the same cycle, remaining=0 -> packet_type 0x01 next cycle.
REQ-031 frame_start, remaining=20 (>= 16), packet_enable -> 0x02 with audio_pop pulse; after remaining drops to 3, next enable -> 0x01.
REQ-032 ACR_PERIOD_FRAMES=3, four frame_starts each followed by one enable -> 0x01 only after the 3rd frame_start; AIF (0x84) granted after every frame_start.
REQ-033 Frame of 300 grants of 0x02, then frame_start -> audio_packets_last_frame = 255; next frame of 5 grants -> 5.
REQ-034 Reset pulse mid-frame with aif_pend set, then enable with remaining=0 -> 0x00, not 0x84.
